// File: rtl/clause_load_scheduler_if.sv
// ---------------------------------------------------------------------------
// clause_load_scheduler_if
// Handshake bundle between the host preload stream, the clause load
// scheduler and the per-engine input buffers.
//
// Signals:
//   host_cla_valid/host_cla/host_cla_ready       host clause stream
//   host_uc_valid/host_uc/host_uc_last/host_uc_ready  host unit-clause stream
//   eng_cla_valid/eng_cla/eng_cla_ready          one-hot clause delivery
//   eng_ptr_valid/eng_ptr                        one-hot tail-pointer strobe
//   eng_uc_valid/eng_uc/eng_uc_ready             unit-clause broadcast
//
// Modports:
//   slave  : the scheduler (consumes host streams, drives engine side)
//   master : the environment (drives host streams, models engine readiness)
// ---------------------------------------------------------------------------
interface clause_load_scheduler_if #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_LENGTH = 3,
  parameter int LIT_W      = 11,
  parameter int CLQ_DEPTH  = 64,
  parameter int PTR_W      = $clog2(CLQ_DEPTH)
);
  logic                          host_cla_valid;
  logic [CLA_LENGTH*LIT_W-1:0]   host_cla;
  logic                          host_cla_ready;
  logic                          host_uc_valid;
  logic [LIT_W-1:0]              host_uc;
  logic                          host_uc_last;
  logic                          host_uc_ready;
  logic [NUM_ENGINE-1:0]         eng_cla_valid;
  logic [CLA_LENGTH*LIT_W-1:0]   eng_cla;
  logic [NUM_ENGINE-1:0]         eng_cla_ready;
  logic [NUM_ENGINE-1:0]         eng_ptr_valid;
  logic [PTR_W-1:0]              eng_ptr;
  logic                          eng_uc_valid;
  logic [LIT_W-1:0]              eng_uc;
  logic [NUM_ENGINE-1:0]         eng_uc_ready;

  modport slave (
    input  host_cla_valid, host_cla,
    output host_cla_ready,
    input  host_uc_valid, host_uc, host_uc_last,
    output host_uc_ready,
    output eng_cla_valid, eng_cla,
    input  eng_cla_ready,
    output eng_ptr_valid, eng_ptr,
    output eng_uc_valid, eng_uc,
    input  eng_uc_ready
  );

  modport master (
    output host_cla_valid, host_cla,
    input  host_cla_ready,
    output host_uc_valid, host_uc, host_uc_last,
    input  host_uc_ready,
    input  eng_cla_valid, eng_cla,
    output eng_cla_ready,
    input  eng_ptr_valid, eng_ptr,
    input  eng_uc_valid, eng_uc,
    output eng_uc_ready
  );
endinterface

// File: rtl/clause_load_scheduler.sv
// ---------------------------------------------------------------------------
// clause_load_scheduler
// Loads preprocessed CNF data into the per-engine clause queues in three
// phases: clauses dealt round-robin (strict order, no skipping of stalled
// engines), one tail-pointer strobe per engine derived from the fill counts,
// then unit clauses broadcast to every engine simultaneously.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   begin a load (sampled only while idle)
//   num_clause  in   total clauses of the load, latched on start
//   bus         if   clause_load_scheduler_if.slave (host + engine handshakes)
//   busy        out  high in any state other than idle
//   done        out  one-cycle pulse at load completion
//   error       out  sticky overflow flag, cleared by the next accepted start
//
// Optional build macro:
//   UC_ZERO_FILTER_EN  when defined, a unit clause of literal 0 is accepted
//                      without waiting for the engines and is not forwarded.
// ---------------------------------------------------------------------------
module clause_load_scheduler #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_LENGTH = 3,
  parameter int LIT_W      = 11,
  parameter int CLQ_DEPTH  = 64,
  parameter int PTR_W      = $clog2(CLQ_DEPTH),
  parameter int CNT_W      = $clog2(NUM_ENGINE*CLQ_DEPTH)+1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_clause,
  clause_load_scheduler_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int FILL_W = PTR_W + 1;  // a full queue holds CLQ_DEPTH entries
  localparam int CLA_W  = CLA_LENGTH * LIT_W;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_ENGINE - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_ENGINE * CLQ_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLA  = 3'd1,
    S_PTR  = 3'd2,
    S_UC   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [CNT_W-1:0]    num_r;
  logic [CNT_W-1:0]    sent_r;
  logic [IDX_W-1:0]    rr_idx_r;
  logic [IDX_W-1:0]    ptr_idx_r;
  logic [FILL_W-1:0]   fill_r [NUM_ENGINE];
  logic                error_r;

  logic [NUM_ENGINE-1:0] cla_valid_s;
  logic [CLA_W-1:0]      cla_data_s;
  logic                  cla_ready_s;
  logic [NUM_ENGINE-1:0] ptr_valid_s;
  logic [PTR_W-1:0]      ptr_s;
  logic                  uc_valid_s;
  logic [LIT_W-1:0]      uc_data_s;
  logic                  uc_ready_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  cla_xfer_s;
  logic                  cla_last_s;
  logic                  uc_xfer_s;

  assign cla_xfer_s = (state_r == S_CLA) && bus.host_cla_valid && cla_ready_s;
  // sent_r counts completed transfers, so this transfer is the final one
  assign cla_last_s = (sent_r == (num_r - CNT_ONE));
  assign uc_xfer_s  = (state_r == S_UC) && bus.host_uc_valid && uc_ready_s;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_clause > CNT_MAX) begin
            next_state_s = S_DONE;
          end else if (num_clause == '0) begin
            next_state_s = S_PTR;
          end else begin
            next_state_s = S_CLA;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CLA: begin
        if (cla_xfer_s && cla_last_s) begin
          next_state_s = S_PTR;
        end else begin
          next_state_s = S_CLA;
        end
      end
      S_PTR: begin
        if (ptr_idx_r == IDX_LAST) begin
          next_state_s = S_UC;
        end else begin
          next_state_s = S_PTR;
        end
      end
      S_UC: begin
        if (uc_xfer_s && bus.host_uc_last) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_UC;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode; the clause and UC handshakes pass through combinationally
  always_comb begin
    cla_valid_s = '0;
    cla_data_s  = '0;
    cla_ready_s = 1'b0;
    ptr_valid_s = '0;
    ptr_s       = '0;
    uc_valid_s  = 1'b0;
    uc_data_s   = '0;
    uc_ready_s  = 1'b0;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_CLA: begin
        cla_data_s            = bus.host_cla;
        cla_valid_s[rr_idx_r] = bus.host_cla_valid;
        cla_ready_s           = bus.eng_cla_ready[rr_idx_r];
      end
      S_PTR: begin
        ptr_valid_s[ptr_idx_r] = 1'b1;
        // Truncation makes a full queue report pointer 0 (wrap)
        ptr_s = fill_r[ptr_idx_r][PTR_W-1:0];
      end
      S_UC: begin
        uc_data_s = bus.host_uc;
`ifdef UC_ZERO_FILTER_EN
        if (bus.host_uc == '0) begin
          uc_valid_s = 1'b0;
          uc_ready_s = 1'b1;
        end else begin
          uc_valid_s = bus.host_uc_valid;
          uc_ready_s = &bus.eng_uc_ready;
        end
`else
        uc_valid_s = bus.host_uc_valid;
        uc_ready_s = &bus.eng_uc_ready;
`endif
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Load bookkeeping: clause count, round-robin index, fill counts, error
  always_ff @(posedge clock) begin
    if (reset) begin
      num_r     <= '0;
      sent_r    <= '0;
      rr_idx_r  <= '0;
      ptr_idx_r <= '0;
      error_r   <= 1'b0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
        fill_r[i] <= '0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            num_r     <= num_clause;
            sent_r    <= '0;
            rr_idx_r  <= '0;
            ptr_idx_r <= '0;
            error_r   <= (num_clause > CNT_MAX);
            for (int i = 0; i < NUM_ENGINE; i++) begin
              fill_r[i] <= '0;
            end
          end
        end
        S_CLA: begin
          if (cla_xfer_s) begin
            fill_r[rr_idx_r] <= fill_r[rr_idx_r] + FILL_ONE;
            rr_idx_r         <= (rr_idx_r == IDX_LAST) ? '0 : (rr_idx_r + IDX_ONE);
            sent_r           <= sent_r + CNT_ONE;
          end
        end
        S_PTR: begin
          ptr_idx_r <= (ptr_idx_r == IDX_LAST) ? '0 : (ptr_idx_r + IDX_ONE);
        end
        default: begin
          num_r <= num_r;
        end
      endcase
    end
  end

  assign bus.eng_cla_valid  = cla_valid_s;
  assign bus.eng_cla        = cla_data_s;
  assign bus.host_cla_ready = cla_ready_s;
  assign bus.eng_ptr_valid  = ptr_valid_s;
  assign bus.eng_ptr        = ptr_s;
  assign bus.eng_uc_valid   = uc_valid_s;
  assign bus.eng_uc         = uc_data_s;
  assign bus.host_uc_ready  = uc_ready_s;
  assign busy               = busy_s;
  assign done               = done_s;
  assign error              = error_r;

endmodule

// File: tb/tb_clause_load_scheduler.sv
// ---------------------------------------------------------------------------
// tb_clause_load_scheduler
// Directed self-checking bench for clause_load_scheduler (4 engines, depth 64).
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units
// later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_clause_load_scheduler;
  localparam int NE    = 4;
  localparam int CL    = 3;
  localparam int LIT_W = 11;
  localparam int DEPTH = 64;
  localparam int PTR_W = 6;
  localparam int CNT_W = 9;
  localparam int CLA_W = CL * LIT_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_clause = '0;
  logic             busy;
  logic             done;
  logic             error;
  int               checks = 0;
  int               failures = 0;

  clause_load_scheduler_if #(.NUM_ENGINE(NE), .CLA_LENGTH(CL), .LIT_W(LIT_W),
                             .CLQ_DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

  clause_load_scheduler #(.NUM_ENGINE(NE), .CLA_LENGTH(CL), .LIT_W(LIT_W),
                          .CLQ_DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_clause (num_clause),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [CLA_W-1:0] cla_pat(input int i);
    return {LIT_W'(i + 1), LIT_W'(i * 3 + 5), LIT_W'(2047 - i)};
  endfunction

  task automatic idle_inputs();
    start              = 1'b0;
    bus.host_cla_valid = 1'b0;
    bus.host_cla       = '0;
    bus.host_uc_valid  = 1'b0;
    bus.host_uc        = '0;
    bus.host_uc_last   = 1'b0;
    bus.eng_cla_ready  = 4'hF;
    bus.eng_uc_ready   = 4'hF;
  endtask

  // Pointer phase, UC phase (n_uc beats, first one stalled 'stall' cycles), done
  task automatic check_tail(input string name, input int p0, input int p1,
                            input int p2, input int p3, input int n_uc, input int stall);
    int pe [4];
    pe = '{p0, p1, p2, p3};
    for (int e = 0; e < NE; e++) begin
      settle();
      checks++;
      if (bus.eng_ptr_valid !== NE'(1 << e) || bus.eng_ptr !== PTR_W'(pe[e])) begin
        failures++;
        $display("FAIL %s_ptr%0d: got valid=%b ptr=%0d expected valid=%b ptr=%0d",
                 name, e, bus.eng_ptr_valid, bus.eng_ptr, NE'(1 << e), pe[e]);
      end
      tick();
    end
    bus.host_uc_valid = 1'b1;
    for (int k = 0; k < n_uc; k++) begin
      bus.host_uc      = LIT_W'(5 + k);
      bus.host_uc_last = (k == n_uc - 1);
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.eng_uc_ready = 4'b1011;
          settle();
          checks++;
          if (bus.host_uc_ready !== 1'b0 || bus.eng_uc_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_uc_stall%0d: got ready=%b valid=%b expected ready=0 valid=1",
                     name, s, bus.host_uc_ready, bus.eng_uc_valid);
          end
          tick();
        end
      end
      bus.eng_uc_ready = 4'hF;
      settle();
      checks++;
      if (bus.eng_uc_valid !== 1'b1 || bus.eng_uc !== LIT_W'(5 + k) ||
          bus.host_uc_ready !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s_uc%0d: got valid=%b uc=%0d ready=%b done=%b expected 1 %0d 1 0",
                 name, k, bus.eng_uc_valid, bus.eng_uc, bus.host_uc_ready, done, 5 + k);
      end
      tick();
    end
    bus.host_uc_valid = 1'b0;
    bus.host_uc_last  = 1'b0;
    settle();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: got done=%b busy=%b expected done=1 busy=1", name, done, busy);
    end
    tick();
    settle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got done=%b busy=%b expected done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.host_cla_valid = 1'b1;
    bus.host_uc_valid  = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if ({busy, done, error, bus.host_cla_ready, bus.host_uc_ready, bus.eng_uc_valid,
         bus.eng_cla_valid, bus.eng_ptr_valid} !== 14'd0 || bus.eng_cla !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b cr=%b ur=%b uv=%b cv=%b pv=%b expected all 0",
               busy, done, error, bus.host_cla_ready, bus.host_uc_ready, bus.eng_uc_valid,
               bus.eng_cla_valid, bus.eng_ptr_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_basic();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd6;
    settle();
    checks++;
    if (busy !== 1'b0 || bus.host_cla_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_start: got busy=%b cla_ready=%b expected 0 0", busy, bus.host_cla_ready);
    end
    tick();
    start = 1'b0;
    bus.host_cla_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.host_cla = cla_pat(i);
      settle();
      checks++;
      if (bus.eng_cla_valid !== NE'(1 << (i % NE)) || bus.eng_cla !== cla_pat(i) ||
          bus.host_cla_ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_cla%0d: got valid=%b data=%h ready=%b busy=%b expected %b %h 1 1",
                 i, bus.eng_cla_valid, bus.eng_cla, bus.host_cla_ready, busy,
                 NE'(1 << (i % NE)), cla_pat(i));
      end
      tick();
    end
    bus.host_cla_valid = 1'b0;
    check_tail("basic", 2, 2, 1, 1, 2, 0);
  endtask

  task automatic test_stall();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd6;
    tick();
    start = 1'b0;
    bus.host_cla_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.host_cla = cla_pat(i);
      if (i == 2) begin
        bus.eng_cla_ready = 4'b1011;
        for (int s = 0; s < 5; s++) begin
          settle();
          checks++;
          if (bus.host_cla_ready !== 1'b0 || bus.eng_cla_valid !== 4'b0100) begin
            failures++;
            $display("FAIL stall_hold%0d: got ready=%b valid=%b expected ready=0 valid=0100",
                     s, bus.host_cla_ready, bus.eng_cla_valid);
          end
          tick();
        end
        bus.eng_cla_ready = 4'hF;
      end
      settle();
      checks++;
      if (bus.eng_cla_valid !== NE'(1 << (i % NE)) || bus.eng_cla !== cla_pat(i) ||
          bus.host_cla_ready !== 1'b1) begin
        failures++;
        $display("FAIL stall_cla%0d: got valid=%b data=%h ready=%b expected %b %h 1",
                 i, bus.eng_cla_valid, bus.eng_cla, bus.host_cla_ready,
                 NE'(1 << (i % NE)), cla_pat(i));
      end
      tick();
    end
    bus.host_cla_valid = 1'b0;
    check_tail("stall", 2, 2, 1, 1, 1, 0);
  endtask

  task automatic test_zero();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd0;
    tick();
    start = 1'b0;
    check_tail("zero", 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    idle_inputs();
    bus.host_cla_valid = 1'b1;
    start = 1'b1;
    num_clause = 9'd257;
    tick();
    start = 1'b0;
    settle();
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || bus.eng_cla_valid !== 4'b0000 ||
        bus.host_cla_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_done: got done=%b err=%b cv=%b cr=%b expected 1 1 0000 0",
               done, error, bus.eng_cla_valid, bus.host_cla_ready);
    end
    tick();
    settle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got done=%b busy=%b err=%b expected 0 0 1", done, busy, error);
    end
    start = 1'b1;
    num_clause = 9'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.host_cla = cla_pat(i + 20);
      settle();
      checks++;
      if (error !== 1'b0 || bus.eng_cla_valid !== NE'(1 << i) || bus.eng_cla !== cla_pat(i + 20)) begin
        failures++;
        $display("FAIL ovf_reload%0d: got err=%b valid=%b data=%h expected 0 %b %h",
                 i, error, bus.eng_cla_valid, bus.eng_cla, NE'(1 << i), cla_pat(i + 20));
      end
      tick();
    end
    bus.host_cla_valid = 1'b0;
    check_tail("ovf", 1, 1, 1, 1, 1, 0);
  endtask

  task automatic test_wrap();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd256;
    tick();
    start = 1'b0;
    bus.host_cla_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.host_cla = cla_pat(i);
      settle();
      checks++;
      if (bus.eng_cla_valid !== NE'(1 << (i % NE)) || bus.host_cla_ready !== 1'b1) begin
        failures++;
        $display("FAIL wrap_cla%0d: got valid=%b ready=%b expected %b 1",
                 i, bus.eng_cla_valid, bus.host_cla_ready, NE'(1 << (i % NE)));
      end
      tick();
    end
    bus.host_cla_valid = 1'b0;
    check_tail("wrap", 0, 0, 0, 0, 1, 3);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd6;
    tick();
    start = 1'b0;
    bus.host_cla_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.host_cla = cla_pat(i);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.host_cla_ready !== 1'b0 ||
        bus.eng_cla_valid !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_idle: got busy=%b done=%b cr=%b cv=%b expected 0 0 0 0000",
               busy, done, bus.host_cla_ready, bus.eng_cla_valid);
    end
    start = 1'b1;
    num_clause = 9'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.host_cla = cla_pat(i + 40);
      settle();
      checks++;
      if (bus.eng_cla_valid !== NE'(1 << i) || bus.eng_cla !== cla_pat(i + 40)) begin
        failures++;
        $display("FAIL rstmid_cla%0d: got valid=%b data=%h expected %b %h",
                 i, bus.eng_cla_valid, bus.eng_cla, NE'(1 << i), cla_pat(i + 40));
      end
      tick();
    end
    bus.host_cla_valid = 1'b0;
    check_tail("rstmid", 1, 1, 0, 0, 1, 0);
  endtask

  task automatic test_uc_zero();
    idle_inputs();
    start = 1'b1;
    num_clause = 9'd0;
    tick();
    start = 1'b0;
    for (int e = 0; e < NE; e++) tick();
    bus.host_uc_valid = 1'b1;
    bus.host_uc       = 11'd5;
    bus.host_uc_last  = 1'b0;
    settle();
    checks++;
    if (bus.eng_uc_valid !== 1'b1 || bus.eng_uc !== 11'd5 || bus.host_uc_ready !== 1'b1) begin
      failures++;
      $display("FAIL ucz_first: got valid=%b uc=%0d ready=%b expected 1 5 1",
               bus.eng_uc_valid, bus.eng_uc, bus.host_uc_ready);
    end
    tick();
    bus.host_uc      = 11'd0;
    bus.host_uc_last = 1'b1;
`ifdef UC_ZERO_FILTER_EN
    bus.eng_uc_ready = 4'b0000;
    settle();
    checks++;
    if (bus.eng_uc_valid !== 1'b0 || bus.host_uc_ready !== 1'b1) begin
      failures++;
      $display("FAIL ucz_filter: got valid=%b ready=%b expected valid=0 ready=1",
               bus.eng_uc_valid, bus.host_uc_ready);
    end
`else
    settle();
    checks++;
    if (bus.eng_uc_valid !== 1'b1 || bus.eng_uc !== 11'd0 || bus.host_uc_ready !== 1'b1) begin
      failures++;
      $display("FAIL ucz_pass: got valid=%b uc=%0d ready=%b expected 1 0 1",
               bus.eng_uc_valid, bus.eng_uc, bus.host_uc_ready);
    end
`endif
    tick();
    idle_inputs();
    settle();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ucz_done: got done=%b expected 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_uc_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
